// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, ALU func3 codes,
// FSM states and the decoded-instruction bundle.
package alu_issue_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_PASS = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]      func3;
    logic            subsra;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            is_lui;
    logic            illegal;
  } dec_t;

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational RV32I ALU-subset decoder. Only the opcode and Instr[31:12]
// matter here; rd is taken directly by the issue FSM.
module alu_issue_ctrl_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [19:0] instr_upper,
  output dec_t        dec
);

  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [11:0] imm12;

  assign funct7 = instr_upper[19:13];
  assign funct3 = instr_upper[2:0];
  assign imm12  = instr_upper[19:8];

  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        dec.func3 = funct3;
        if (funct7 == F7_BASE && funct3 != F3_PASS) begin
          dec.illegal = 1'b0;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec.illegal = 1'b0;
          dec.subsra  = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.func3   = funct3;
        dec.use_imm = 1'b1;
        dec.imm     = {{(XLEN-12){imm12[11]}}, imm12};
        if (funct3 == F3_PASS) begin
          dec.illegal = 1'b1;
        end else if (is_shift(funct3)) begin
          // SRAI would need subsra; only logical immediate shifts are issued
          dec.illegal = (funct7 != F7_BASE);
        end else begin
          dec.illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.func3   = F3_PASS;
        dec.use_imm = 1'b1;
        dec.is_lui  = 1'b1;
        dec.imm     = {instr_upper, 12'b0};
        dec.illegal = 1'b0;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue stage in front of a single-cycle ALU: accept, read
// registers, execute, then hold the writeback until the regfile takes it.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             InstrValid,
  output logic             InstrReady,
  input  logic [31:0]      Instr,
  output logic [RADDR-1:0] RFrs1Addr,
  output logic [RADDR-1:0] RFrs2Addr,
  input  logic [XLEN-1:0]  RFrs1Data,
  input  logic [XLEN-1:0]  RFrs2Data,
  output logic [XLEN-1:0]  ALUoperand1,
  output logic [XLEN-1:0]  ALUoperand2,
  output logic [2:0]       ALUfunc3,
  output logic             ALUsubsra,
  input  logic [XLEN-1:0]  ALUresult,
  output logic             WBValid,
  input  logic             WBReady,
  output logic [RADDR-1:0] WBAddr,
  output logic [XLEN-1:0]  WBData,
  output logic             Illegal
);

  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [RADDR-1:0] rs1_q, rs1_d;
  logic [RADDR-1:0] rs2_q, rs2_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  op1_q, op1_d;
  logic [XLEN-1:0]  op2_q, op2_d;
  logic [2:0]       func3_q, func3_d;
  logic             subsra_q, subsra_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             wb_valid_q, wb_valid_d;
  logic             illegal_q, illegal_d;

  dec_t            dec;
  logic [XLEN-1:0] op2_src;

  alu_issue_ctrl_decode u_decode (
    .opcode      (instr_q[6:0]),
    .instr_upper (instr_q[31:12]),
    .dec         (dec)
  );

  // Shift amounts are masked to 5 bits so the ALU never sees a wider shift
  always_comb begin
    op2_src = dec.use_imm ? dec.imm : RFrs2Data;
    if (!dec.is_lui && is_shift(dec.func3)) begin
      op2_src = {{(XLEN-5){1'b0}}, op2_src[4:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    func3_d    = func3_q;
    subsra_d   = subsra_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = wb_valid_q;
    illegal_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (InstrValid) begin
          instr_d = Instr;
          rs1_d   = Instr[19:15];
          rs2_d   = Instr[24:20];
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (dec.illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          op1_d    = dec.is_lui ? '0 : RFrs1Data;
          op2_d    = op2_src;
          func3_d  = dec.func3;
          subsra_d = dec.subsra;
          rd_d     = instr_q[11:7];
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wb_data_d = ALUresult;
        if (rd_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          wb_valid_d = 1'b1;
          state_d    = ST_WB;
        end
      end
      ST_WB: begin
        if (WBReady) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      func3_q    <= '0;
      subsra_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      func3_q    <= func3_d;
      subsra_q   <= subsra_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign InstrReady  = (state_q == ST_IDLE) && !rst;
  assign RFrs1Addr   = rs1_q;
  assign RFrs2Addr   = rs2_q;
  assign ALUoperand1 = op1_q;
  assign ALUoperand2 = op2_q;
  assign ALUfunc3    = func3_q;
  assign ALUsubsra   = subsra_q;
  assign WBValid     = wb_valid_q;
  assign WBAddr      = rd_q;
  assign WBData      = wb_data_q;
  assign Illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural regfile and ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [4:0]  RFrs1Addr, RFrs2Addr;
  logic [31:0] RFrs1Data, RFrs2Data;
  logic [31:0] ALUoperand1, ALUoperand2;
  logic [2:0]  ALUfunc3;
  logic        ALUsubsra;
  logic [31:0] ALUresult;
  logic        WBValid;
  logic        WBReady;
  logic [4:0]  WBAddr;
  logic [31:0] WBData;
  logic        Illegal;

  int tests = 0;
  int fails = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .RFrs1Addr(RFrs1Addr), .RFrs2Addr(RFrs2Addr),
    .RFrs1Data(RFrs1Data), .RFrs2Data(RFrs2Data),
    .ALUoperand1(ALUoperand1), .ALUoperand2(ALUoperand2),
    .ALUfunc3(ALUfunc3), .ALUsubsra(ALUsubsra), .ALUresult(ALUresult),
    .WBValid(WBValid), .WBReady(WBReady), .WBAddr(WBAddr), .WBData(WBData),
    .Illegal(Illegal)
  );

  assign RFrs1Data = rf[RFrs1Addr];
  assign RFrs2Data = rf[RFrs2Addr];

  always_comb begin
    ALUresult = 32'h0;
    case (ALUfunc3)
      3'b000: ALUresult = ALUsubsra ? ALUoperand1 - ALUoperand2 : ALUoperand1 + ALUoperand2;
      3'b001: ALUresult = ALUoperand1 << ALUoperand2[4:0];
      3'b010: ALUresult = {31'b0, $signed(ALUoperand1) < $signed(ALUoperand2)};
      3'b011: ALUresult = ALUoperand2;
      3'b100: ALUresult = ALUoperand1 ^ ALUoperand2;
      3'b101: ALUresult = ALUsubsra ? $unsigned($signed(ALUoperand1) >>> ALUoperand2[4:0])
                                    : ALUoperand1 >> ALUoperand2[4:0];
      3'b110: ALUresult = ALUoperand1 | ALUoperand2;
      default: ALUresult = ALUoperand1 & ALUoperand2;
    endcase
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Presents one instruction in IDLE; returns at the negedge after the accept edge.
  task automatic accept(input logic [31:0] ins);
    int n = 0;
    @(negedge clk);
    while (!InstrReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout InstrReady=%0b expected 1", InstrReady);
    end
    InstrValid = 1'b1;
    Instr      = ins;
    @(negedge clk);
    InstrValid = 1'b0;
    Instr      = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (InstrReady !== 1'b0 || WBValid !== 1'b0 || Illegal !== 1'b0 ||
        ALUoperand1 !== 32'h0 || ALUoperand2 !== 32'h0 || ALUfunc3 !== 3'h0 ||
        ALUsubsra !== 1'b0 || WBAddr !== 5'h0 || WBData !== 32'h0 ||
        RFrs1Addr !== 5'h0 || RFrs2Addr !== 5'h0) begin
      fails++;
      $display("FAIL reset_outputs rdy=%0b wbv=%0b ill=%0b op1=%h op2=%h f3=%0d wba=%0d wbd=%h expected all 0",
               InstrReady, WBValid, Illegal, ALUoperand1, ALUoperand2, ALUfunc3, WBAddr, WBData);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got %0b expected 1", InstrReady);
    end
  endtask

  task automatic test_add();
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    accept(enc_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2));
    tests++;
    if (RFrs1Addr !== 5'd1 || RFrs2Addr !== 5'd2 || WBValid !== 1'b0 || InstrReady !== 1'b0) begin
      fails++;
      $display("FAIL add_read rs1=%0d rs2=%0d wbv=%0b rdy=%0b expected 1 2 0 0",
               RFrs1Addr, RFrs2Addr, WBValid, InstrReady);
    end
    @(negedge clk);
    tests++;
    if (ALUoperand1 !== 32'd5 || ALUoperand2 !== 32'd7 || ALUfunc3 !== 3'b000 ||
        ALUsubsra !== 1'b0 || WBValid !== 1'b0) begin
      fails++;
      $display("FAIL add_exec op1=%h op2=%h f3=%0d sub=%0b wbv=%0b expected 5 7 0 0 0",
               ALUoperand1, ALUoperand2, ALUfunc3, ALUsubsra, WBValid);
    end
    @(negedge clk);
    tests++;
    if (WBValid !== 1'b1 || WBAddr !== 5'd3 || WBData !== 32'd12 || InstrReady !== 1'b0) begin
      fails++;
      $display("FAIL add_wb wbv=%0b wba=%0d wbd=%h rdy=%0b expected 1 3 0000000c 0",
               WBValid, WBAddr, WBData, InstrReady);
    end
    WBReady = 1'b1;
    @(negedge clk);
    WBReady = 1'b0;
    tests++;
    if (WBValid !== 1'b0 || InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL add_retire wbv=%0b rdy=%0b expected 0 1", WBValid, InstrReady);
    end
  endtask

  task automatic test_sub();
    accept(enc_r(7'b0100000, 3'b000, 5'd4, 5'd1, 5'd2));
    @(negedge clk);
    tests++;
    if (ALUsubsra !== 1'b1 || ALUfunc3 !== 3'b000) begin
      fails++;
      $display("FAIL sub_exec sub=%0b f3=%0d expected 1 0", ALUsubsra, ALUfunc3);
    end
    @(negedge clk);
    tests++;
    if (WBValid !== 1'b1 || WBAddr !== 5'd4 || WBData !== 32'hFFFFFFFE) begin
      fails++;
      $display("FAIL sub_wb wbv=%0b wba=%0d wbd=%h expected 1 4 fffffffe", WBValid, WBAddr, WBData);
    end
    WBReady = 1'b1;
    @(negedge clk);
    WBReady = 1'b0;
  endtask

  task automatic test_shift_imm();
    rf[1] = 32'd1;
    rf[2] = 32'h21;
    accept(enc_r(7'b0000000, 3'b001, 5'd5, 5'd1, 5'd2));
    @(negedge clk);
    tests++;
    if (ALUoperand2 !== 32'd1 || ALUfunc3 !== 3'b001) begin
      fails++;
      $display("FAIL sll_op2 op2=%h f3=%0d expected 00000001 1", ALUoperand2, ALUfunc3);
    end
    @(negedge clk);
    tests++;
    if (WBData !== 32'd2 || WBAddr !== 5'd5) begin
      fails++;
      $display("FAIL sll_wb wbd=%h wba=%0d expected 00000002 5", WBData, WBAddr);
    end
    WBReady = 1'b1;
    @(negedge clk);
    WBReady = 1'b0;
    accept(enc_i(12'd4, 3'b001, 5'd5, 5'd1));
    @(negedge clk);
    tests++;
    if (ALUoperand2 !== 32'd4) begin
      fails++;
      $display("FAIL slli_op2 op2=%h expected 00000004", ALUoperand2);
    end
    @(negedge clk);
    tests++;
    if (WBData !== 32'h10) begin
      fails++;
      $display("FAIL slli_wb wbd=%h expected 00000010", WBData);
    end
    WBReady = 1'b1;
    @(negedge clk);
    WBReady = 1'b0;
    accept(enc_i(12'hFFD, 3'b000, 5'd7, 5'd1));
    @(negedge clk);
    tests++;
    if (ALUoperand2 !== 32'hFFFFFFFD || ALUoperand1 !== 32'd1) begin
      fails++;
      $display("FAIL addi_sext op1=%h op2=%h expected 00000001 fffffffd", ALUoperand1, ALUoperand2);
    end
    @(negedge clk);
    tests++;
    if (WBData !== 32'hFFFFFFFE || WBAddr !== 5'd7) begin
      fails++;
      $display("FAIL addi_wb wbd=%h wba=%0d expected fffffffe 7", WBData, WBAddr);
    end
    WBReady = 1'b1;
    @(negedge clk);
    WBReady = 1'b0;
  endtask

  task automatic test_lui();
    accept(enc_u(20'h12345, 5'd6));
    @(negedge clk);
    tests++;
    if (ALUfunc3 !== 3'b011 || ALUoperand1 !== 32'h0 || ALUoperand2 !== 32'h12345000 ||
        ALUsubsra !== 1'b0) begin
      fails++;
      $display("FAIL lui_exec f3=%0d op1=%h op2=%h sub=%0b expected 3 0 12345000 0",
               ALUfunc3, ALUoperand1, ALUoperand2, ALUsubsra);
    end
    @(negedge clk);
    tests++;
    if (WBData !== 32'h12345000 || WBAddr !== 5'd6 || WBValid !== 1'b1) begin
      fails++;
      $display("FAIL lui_wb wbd=%h wba=%0d wbv=%0b expected 12345000 6 1", WBData, WBAddr, WBValid);
    end
    WBReady = 1'b1;
    @(negedge clk);
    WBReady = 1'b0;
  endtask

  // Runs right after test_lui, so the ALU operands must still show the LUI values.
  task automatic test_illegal();
    logic [31:0] bad [4];
    bad[0] = enc_r(7'b0100000, 3'b101, 5'd8, 5'd1, 5'd2);
    bad[1] = enc_r(7'b0000000, 3'b011, 5'd8, 5'd1, 5'd2);
    bad[2] = enc_i({7'b0100000, 5'd3}, 3'b101, 5'd8, 5'd1);
    bad[3] = {12'h004, 5'd1, 3'b010, 5'd8, 7'b0000011};
    for (int k = 0; k < 4; k++) begin
      accept(bad[k]);
      tests++;
      if (Illegal !== 1'b0) begin
        fails++;
        $display("FAIL illegal_early[%0d] ill=%0b expected 0", k, Illegal);
      end
      @(negedge clk);
      tests++;
      if (Illegal !== 1'b1 || WBValid !== 1'b0 || InstrReady !== 1'b1 ||
          ALUoperand2 !== 32'h12345000 || ALUfunc3 !== 3'b011) begin
        fails++;
        $display("FAIL illegal_pulse[%0d] ill=%0b wbv=%0b rdy=%0b op2=%h f3=%0d expected 1 0 1 12345000 3",
                 k, Illegal, WBValid, InstrReady, ALUoperand2, ALUfunc3);
      end
      @(negedge clk);
      tests++;
      if (Illegal !== 1'b0 || WBValid !== 1'b0) begin
        fails++;
        $display("FAIL illegal_clear[%0d] ill=%0b wbv=%0b expected 0 0", k, Illegal, WBValid);
      end
    end
  endtask

  task automatic test_backpressure();
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    accept(enc_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2));
    @(negedge clk);
    @(negedge clk);
    InstrValid = 1'b1;
    Instr      = enc_r(7'b0100000, 3'b000, 5'd9, 5'd2, 5'd1);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (WBValid !== 1'b1 || WBData !== 32'd12 || WBAddr !== 5'd3 || InstrReady !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d] wbv=%0b wbd=%h wba=%0d rdy=%0b expected 1 0000000c 3 0",
                 i, WBValid, WBData, WBAddr, InstrReady);
      end
      @(negedge clk);
    end
    InstrValid = 1'b0;
    Instr      = 32'h0;
    WBReady    = 1'b1;
    @(negedge clk);
    WBReady = 1'b0;
    tests++;
    if (WBValid !== 1'b0 || InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL bp_release wbv=%0b rdy=%0b expected 0 1", WBValid, InstrReady);
    end
  endtask

  task automatic test_rd_zero();
    WBReady = 1'b1;
    accept(enc_r(7'b0000000, 3'b110, 5'd0, 5'd1, 5'd2));
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (WBValid !== 1'b0 || InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL rd0_nowb wbv=%0b rdy=%0b expected 0 1", WBValid, InstrReady);
    end
    WBReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    accept(enc_r(7'b0000000, 3'b100, 5'd10, 5'd1, 5'd2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (InstrReady !== 1'b0 || WBValid !== 1'b0 || Illegal !== 1'b0 ||
        ALUoperand1 !== 32'h0 || ALUoperand2 !== 32'h0 || ALUfunc3 !== 3'h0 ||
        WBAddr !== 5'h0 || WBData !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid rdy=%0b wbv=%0b ill=%0b op1=%h op2=%h f3=%0d wba=%0d wbd=%h expected all 0",
               InstrReady, WBValid, Illegal, ALUoperand1, ALUoperand2, ALUfunc3, WBAddr, WBData);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (WBValid !== 1'b0 || InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_drop wbv=%0b rdy=%0b expected 0 1", WBValid, InstrReady);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    InstrValid = 1'b0;
    Instr      = 32'h0;
    WBReady    = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'h0;
    test_reset();
    test_add();
    test_sub();
    test_shift_imm();
    test_lui();
    test_illegal();
    test_backpressure();
    test_rd_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
